// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, controller states and the flag bundle.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_XOR  = 4'b1001,
    OP_SLTU = 4'b1010,
    OP_MULH = 4'b1011
  } op_t;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial-product add per cycle while run is high.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               run,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  // product is taken from the adder so the final iteration's sum is usable on the done cycle
  assign product  = acc_next;
  assign done     = run && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= b;
      cnt_q    <= CNT_W'(WIDTH - 1);
    end else if (run) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered result/flags behind valid/ready, single-cycle ops plus iterative MUL/MULH.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  state_t             state_q, state_d;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  flags_t             flags_q;
  logic               mulh_q;

  logic               accept, is_mul, mul_start, mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   alu_res, mul_res;
  flags_t             alu_flg, mul_flg;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [SHIFT_W-1:0] shamt;
  logic               shamt_big;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign busy      = (state_q == MUL);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL) || (op == OP_MULH);
  assign mul_start = accept && is_mul;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .run     (busy),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  assign shamt = b[SHIFT_W-1:0];

  always_comb begin
    alu_res   = '0;
    alu_flg   = '0;
    sum_w     = {1'b0, a} + {1'b0, b};
    diff_w    = {1'b0, a} - {1'b0, b};
    shamt_big = (int'(shamt) >= WIDTH);
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_ADD: begin
        alu_res       = sum_w[WIDTH-1:0];
        alu_flg.carry = sum_w[WIDTH];
        alu_flg.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // the extra MSB of the widened difference is exactly the unsigned borrow
        alu_res       = diff_w[WIDTH-1:0];
        alu_flg.carry = diff_w[WIDTH];
        alu_flg.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  alu_res = shamt_big ? '0 : (a << shamt);
      OP_SRL:  alu_res = shamt_big ? '0 : (a >> shamt);
      OP_SRA:  alu_res = shamt_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> shamt);
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_res = WIDTH'(a < b);
      default: alu_res = '0;
    endcase
    alu_flg.zero = (alu_res == '0);
    alu_flg.neg  = alu_res[WIDTH-1];
  end

  always_comb begin
    mul_res       = mulh_q ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
    mul_flg       = '0;
    mul_flg.carry = |product[2*WIDTH-1:WIDTH];
    mul_flg.zero  = (mul_res == '0);
    mul_flg.neg   = mul_res[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (mul_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      mulh_q      <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        out_valid_q <= 1'b0;
        mulh_q      <= (op == OP_MULH);
      end else begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res;
        flags_q     <= alu_flg;
      end
    end else if (mul_done) begin
      out_valid_q <= 1'b1;
      result_q    <= mul_res;
      flags_q     <= mul_flg;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8): directed vectors with literal expectations plus a per-cycle scoreboard.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic         in_ready, out_valid, carry, zero, neg, ovf, busy;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;   // {carry, zero, neg, ovf}
    bit         is_mul;
    int         t_acc;
    bit         seen;
  } exp_t;

  exp_t q[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int ux, uy, sx, sy, v, sh;
    logic c, ov;
    e  = '{r: 8'h00, f: 4'h0, is_mul: 1'b0, t_acc: 0, seen: 1'b0};
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    sh = uy % W;
    c = 1'b0; ov = 1'b0; v = 0;
    case (o)
      4'h0: v = ux & uy;
      4'h1: v = ux | uy;
      4'h9: v = ux ^ uy;
      4'h2: begin v = ux + uy; c = (v > 255); ov = (sx + sy > 127) || (sx + sy < -128); end
      4'h3: begin v = ux - uy; c = (ux < uy); ov = (sx - sy > 127) || (sx - sy < -128); end
      4'h4: v = ux << sh;
      4'h5: v = ux >> sh;
      4'h6: v = sx >>> sh;
      4'h7: v = (sx < sy) ? 1 : 0;
      4'hA: v = (ux < uy) ? 1 : 0;
      4'h8: begin v = ux * uy; c = (v > 255); e.is_mul = 1'b1; end
      4'hB: begin v = (ux * uy) / 256; c = (ux * uy > 255); e.is_mul = 1'b1; end
      default: v = 0;
    endcase
    e.r = 8'(v);
    e.f = {c, e.r == 8'h00, e.r[7], ov};
    return e;
  endfunction

  // Scoreboard: checks outputs, latency, busy and in_ready every cycle.
  always @(negedge clk) begin
    bit busy_exp;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            chk("latency", 32'(cyc - q[0].t_acc - 1), q[0].is_mul ? 32'(W) : 32'd0);
          end
          chk("sb_result", 32'(result), 32'(q[0].r));
          chk("sb_flags", 32'({carry, zero, neg, ovf}), 32'(q[0].f));
          if (out_ready) void'(q.pop_front());
        end
      end
      busy_exp = 1'b0;
      foreach (q[i]) if (q[i].is_mul && !q[i].seen) busy_exp = 1'b1;
      chk("sb_busy", 32'(busy), 32'(busy_exp));
      chk("sb_in_ready", 32'(in_ready), 32'(!busy_exp && (!out_valid || out_ready)));
      if (in_valid && in_ready) begin
        e = model(op, a, b);
        e.t_acc = cyc;
        q.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    bit ok;
    in_valid = 1'b1; op = o; a = x; b = y;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input logic [7:0] er, input logic [3:0] ef,
                          input int exp_busy);
    bit ok;
    int nb;
    ok = 1'b0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
      if (busy) nb++;
    end
    chk({nm, "_valid"}, 32'(ok), 32'd1);
    chk({nm, "_result"}, 32'(result), 32'(er));
    chk({nm, "_flags"}, 32'({carry, zero, neg, ovf}), 32'(ef));
    chk({nm, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    @(posedge clk); #1;
  endtask

  task automatic run(input string nm, input logic [3:0] o, input logic [7:0] x,
                     input logic [7:0] y, input logic [7:0] er, input logic [3:0] ef);
    send(o, x, y);
    wait_out(nm, er, ef, (o == OP_MUL || o == OP_MULH) ? W : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held_r;
    logic [3:0] held_f;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 32'({out_valid, busy, carry, zero, neg, ovf}), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // flags literal order: {carry, zero, neg, ovf}
    run("add_f0_20",  OP_ADD,  8'hF0, 8'h20, 8'h10, 4'b1000);
    run("add_7f_01",  OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b0011);
    run("sub_05_07",  OP_SUB,  8'h05, 8'h07, 8'hFE, 4'b1010);
    run("sub_33_33",  OP_SUB,  8'h33, 8'h33, 8'h00, 4'b0100);
    run("sub_80_01",  OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b0001);
    run("sra_90_03",  OP_SRA,  8'h90, 8'h03, 8'hF2, 4'b0010);
    run("sra_90_0f",  OP_SRA,  8'h90, 8'h0F, 8'hFF, 4'b0010);
    run("sll_00_08",  OP_SLL,  8'h00, 8'h08, 8'h00, 4'b0100);
    run("sll_81_01",  OP_SLL,  8'h81, 8'h01, 8'h02, 4'b0000);
    run("srl_81_04",  OP_SRL,  8'h81, 8'h04, 8'h08, 4'b0000);
    run("slt_ff_01",  OP_SLT,  8'hFF, 8'h01, 8'h01, 4'b0000);
    run("sltu_ff_01", OP_SLTU, 8'hFF, 8'h01, 8'h00, 4'b0100);
    run("and_f0_3c",  OP_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000);
    run("or_f0_0c",   OP_OR,   8'hF0, 8'h0C, 8'hFC, 4'b0010);
    run("xor_a5_0f",  OP_XOR,  8'hA5, 8'h0F, 8'hAA, 4'b0010);
    run("illegal_c",  4'hC,    8'h12, 8'h34, 8'h00, 4'b0100);
    run("mul_0f_11",  OP_MUL,  8'h0F, 8'h11, 8'hFF, 4'b0010);
    run("mulh_20_10", OP_MULH, 8'h20, 8'h10, 8'h02, 4'b1000);
    run("mul_ff_ff",  OP_MUL,  8'hFF, 8'hFF, 8'h01, 4'b1000);

    // Back-to-back single-cycle ops with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; op = 4'(i); a = 8'(8'h3A * i + 7); b = 8'(8'h55 + 3 * i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Backpressure: result held for 3 cycles, then same-cycle accept on out_ready rise.
    out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02);
    in_valid = 1'b1; op = OP_SUB; a = 8'h09; b = 8'h04;
    @(negedge clk);
    held_r = result; held_f = {carry, zero, neg, ovf};
    chk("bp_first_result", 32'(held_r), 32'h03);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", 32'({result, carry, zero, neg, ovf}), 32'({held_r, held_f}));
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_result", 32'({out_valid, result}), 32'({1'b1, 8'h05}));
    @(posedge clk); #1;

    // Reset in the 4th cycle of a multiply aborts it.
    send(OP_MUL, 8'h0F, 8'h11);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 32'({out_valid, busy, carry, zero, neg, ovf}), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    run("add_after_abort", OP_ADD, 8'h01, 8'h01, 8'h02, 4'b0000);

    repeat (12) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU: successor to the 6-bit combinational mini ALU. It takes a generic WIDTH, registers its result and flags behind a valid/ready handshake, and adds an iterative shift-add multiplier (low and high half) alongside the existing single-cycle op set. It sits between an operand source, such as a register file or the pin-mux front end, and a consumer that may apply backpressure.

## Interface
- WIDTH, 8: operand/result width, ≥ 4.
- SHIFT_W, $clog2(WIDTH): derived, shift-amount width; not to be overridden.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  opcode; see Operation.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- carry, zero, neg, ovf  out  1 each  registered flags.
- busy  out  1  high while a multiply is iterating.

## Operation
- Opcodes:
  - AND 0000, OR 0001, ADD 0010, SUB 0011.
  - SLL 0100, SRL 0101, SRA 0110.
  - SLT 0111 (signed), MUL 1000 (low WIDTH bits), XOR 1001.
  - SLTU 1010, MULH 1011 (unsigned high WIDTH bits).
  - Any other opcode gives result 0 with the flags computed from that 0 result.
- Shift amount is b[SHIFT_W-1:0]. If the amount is ≥ WIDTH:
  - SLL and SRL give 0.
  - SRA gives WIDTH copies of a[WIDTH-1].
- Flags:
  - carry: ADD carry-out; SUB borrow (1 when a < b unsigned); MUL/MULH 1 if the high half is nonzero; else 0.
  - ovf: signed overflow for ADD/SUB; else 0.
  - zero: result == 0.
  - neg: result[WIDTH-1].
- SLT and SLTU return 1 or 0, zero-extended to WIDTH.
- States:
  - IDLE: in_ready = !out_valid || out_ready.
  - MUL: in_ready = 0, busy = 1.
- Accept happens when in_valid && in_ready.
  - Single-cycle op: result and flags load, out_valid goes to 1, state stays IDLE.
  - MUL/MULH: operands latch, 2·WIDTH-bit accumulator clears, counter loads WIDTH-1, state goes to MUL.
- MUL state does one shift-add iteration per cycle.
  - On the iteration where the counter is 0: load result and flags, set out_valid, return to IDLE.
- out_valid clears on out_valid && out_ready unless a new accept happens in the same cycle; a new accept wins and loads the new result.
- result and flags are stable while out_valid && !out_ready.

## Timing
- Reset values (all outputs 0):
  - result = 0; carry, zero, neg, ovf = 0.
  - out_valid = 0, busy = 0, state IDLE, in_ready = 1.
- Single-cycle ops: latency 1. Accept at edge k gives out_valid high after edge k.
- MUL/MULH: latency WIDTH. Accept at edge k gives out_valid high after edge k+WIDTH.
- Throughput:
  - Single-cycle ops: 1 per cycle while out_ready = 1.
  - Multiply: 1 per WIDTH+1 cycles at best.
- in_ready is combinational from state, out_valid and out_ready; there is no combinational path from in_valid to in_ready.
- Reset mid-MUL aborts the multiply. The next cycle is IDLE with all outputs 0; partial product is discarded.
- Reset takes priority over any accept in the same cycle.

## Structure
- Package alu_mc_pkg holds:
  - opcode localparams (op_t);
  - the state enum (IDLE, MUL);
  - the flag-bundle struct (carry, zero, neg, ovf).
- One sub-module, alu_mul_iter: latched operands, accumulator, counter, start/done pulses, a WIDTH×WIDTH → 2·WIDTH unsigned product.
- Single-cycle datapath and flag logic live inline in alu_mc as a combinational function of op, a and b.

## Test plan
- WIDTH=8, ADD a=F0 b=20 -> result 10, carry 1, ovf 0, zero 0, one cycle after accept.
- ADD 7F+01 -> 80, ovf 1, neg 1.
- SUB 05-07 -> FE, carry 1, neg 1.
- SUB 33-33 -> 00, zero 1.
- SRA a=90 b=03 -> F2.
- SRA a=90 b=0F -> FF.
- SLL b=08 -> 00.
- SLT a=FF b=01 -> 01.
- SLTU a=FF b=01 -> 00.
- MUL 0F×11 -> FF, carry 0; out_valid exactly 8 cycles after accept; busy high for those 8 cycles and in_ready low throughout.
- MULH 20×10 -> 02, carry 1.
- Backpressure: hold out_ready=0 for 3 cycles after a result. result/flags remain constant and in_ready stays 0. Raising out_ready with in_valid high accepts the next op in that same cycle.
- rst asserted in the 4th cycle of a MUL -> next cycle all outputs 0, in_ready 1. A following ADD 01+01 returns 02 with latency 1.
